// File: rtl/seletor_varredura_if.sv
// Control/status bundle between the scan controller and the seletor_varredura
// sequencer that drives the downstream 2-to-4 decoder.
interface seletor_varredura_if;
    logic       start;
    logic       stop;
    logic       continuous;
    logic [3:0] mask;
    logic [1:0] a1;
    logic       en;
    logic       busy;
    logic       done;

    modport master (
        output start, stop, continuous, mask,
        input  a1, en, busy, done
    );

    modport slave (
        input  start, stop, continuous, mask,
        output a1, en, busy, done
    );
endinterface

// File: rtl/seletor_varredura.sv
// Scan sequencer: walks the enabled decoder lines in order, holding en high for
// DIV cycles per slot with a one-cycle blanking gap between slots.
module seletor_varredura #(
    parameter int DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seletor_varredura_if.slave   bus
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        BLANK
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_a1;
    logic            r_en;
    logic            r_busy;
    logic            r_done;

    logic [1:0]      w_first;
    logic            w_firstValid;
    logic [1:0]      w_next;
    logic            w_nextValid;

    // Lowest set mask bit overall, and lowest set bit above the current slot.
    always_comb begin
        w_first      = 2'd0;
        w_firstValid = 1'b0;
        w_next       = 2'd0;
        w_nextValid  = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.mask[i]) begin
                w_first      = 2'(i);
                w_firstValid = 1'b1;
                if (i > int'(r_a1)) begin
                    w_next      = 2'(i);
                    w_nextValid = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a1    <= 2'd0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_en   <= 1'b0;
                    r_busy <= 1'b0;
                    if (bus.start && !bus.stop && w_firstValid) begin
                        r_a1    <= w_first;
                        r_cnt   <= '0;
                        r_en    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= SHOW;
                    end
                end
                SHOW: begin
                    if (bus.stop) begin
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else if (r_cnt == LAST) begin
                        // Select only moves on the edge that drops en.
                        if (w_nextValid) begin
                            r_a1    <= w_next;
                            r_en    <= 1'b0;
                            r_state <= BLANK;
                        end else if (bus.continuous && w_firstValid) begin
                            r_a1    <= w_first;
                            r_en    <= 1'b0;
                            r_state <= BLANK;
                        end else begin
                            r_en    <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                BLANK: begin
                    if (bus.stop) begin
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= '0;
                        r_en    <= 1'b1;
                        r_state <= SHOW;
                    end
                end
                default: begin
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.a1   = r_a1;
    assign bus.en   = r_en;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_seletor_varredura.sv
// Directed self-checking bench for seletor_varredura with DIV=4.
module tb_seletor_varredura;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    seletor_varredura_if bus ();

    seletor_varredura #(.DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic sp, input logic cont, input logic [3:0] m);
        bus.start      = st;
        bus.stop       = sp;
        bus.continuous = cont;
        bus.mask       = m;
    endtask

    // Packed status {busy, done, en, a1[1:0]}.
    task automatic checkCycle(input string tag, input logic b, input logic d, input logic e, input logic [1:0] a);
        checkOutput(tag, {3'b000, bus.busy, bus.done, bus.en, bus.a1}, {3'b000, b, d, e, a});
    endtask

    // Called in the first SHOW cycle; walks a single pass over n slots.
    task automatic expectPass(input string tag, input int n, input logic [1:0] s0, input logic [1:0] s1,
                              input logic [1:0] s2, input logic [1:0] s3, input int holdStart,
                              input int changeAt, input logic [3:0] newMask);
        logic [1:0] slots [4];
        int cyc;
        slots[0] = s0; slots[1] = s1; slots[2] = s2; slots[3] = s3;
        cyc = 0;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 4; c++) begin
                checkCycle(tag, 1'b1, 1'b0, 1'b1, slots[i]);
                if (cyc >= holdStart) bus.start = 1'b0;
                if (cyc == changeAt) bus.mask = newMask;
                cyc++;
                nextCycle();
            end
            if (i < n - 1) begin
                checkCycle(tag, 1'b1, 1'b0, 1'b0, slots[i+1]);
                if (cyc >= holdStart) bus.start = 1'b0;
                cyc++;
                nextCycle();
            end
        end
        checkCycle({tag, "_done"}, 1'b0, 1'b1, 1'b0, slots[n-1]);
        nextCycle();
        checkCycle({tag, "_after"}, 1'b0, 1'b0, 1'b0, slots[n-1]);
    endtask

    // Select must never move while en is high on both sides of an edge.
    logic       prevEn;
    logic [1:0] prevA1;
    always @(negedge clk) begin
        prevEn = bus.en;
        prevA1 = bus.a1;
    end
    always @(posedge clk) begin
        #1;
        if (rst_n && prevEn && bus.en)
            checkOutput("glitchA1", {6'd0, bus.a1}, {6'd0, prevA1});
    end

    initial begin
        checks   = 0;
        failures = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        rst_n = 1'b0;
        #12;
        checkCycle("reset", 1'b0, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;
        nextCycle();
        checkCycle("idleAfterReset", 1'b0, 1'b0, 1'b0, 2'd0);

        // Full single pass over all four lines.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1111);
        nextCycle();
        bus.start = 1'b0;
        expectPass("pass1111", 4, 2'd0, 2'd1, 2'd2, 2'd3, 0, -1, 4'b1111);

        // Skip mask.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1010);
        nextCycle();
        bus.start = 1'b0;
        expectPass("pass1010", 2, 2'd1, 2'd3, 2'd0, 2'd0, 0, -1, 4'b1010);

        // Start with empty mask, and start together with stop, are both ignored.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        nextCycle();
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkCycle("startMask0", 1'b0, 1'b0, 1'b0, 2'd3);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b1111);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111);
        for (int k = 0; k < 3; k++) begin
            checkCycle("startStopIdle", 1'b0, 1'b0, 1'b0, 2'd3);
            nextCycle();
        end

        // Start held high while busy does not disturb the pass.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0101);
        nextCycle();
        expectPass("startBusy", 2, 2'd0, 2'd2, 2'd0, 2'd0, 6, -1, 4'b0101);

        // Continuous wrap over lines 0 and 3, then abort.
        applyStimulus(1'b1, 1'b0, 1'b1, 4'b1001);
        nextCycle();
        bus.start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                checkCycle("contSlot0", 1'b1, 1'b0, 1'b1, 2'd0);
                nextCycle();
            end
            checkCycle("contBlank0", 1'b1, 1'b0, 1'b0, 2'd3);
            nextCycle();
            for (int c = 0; c < 4; c++) begin
                checkCycle("contSlot3", 1'b1, 1'b0, 1'b1, 2'd3);
                nextCycle();
            end
            checkCycle("contBlank3", 1'b1, 1'b0, 1'b0, 2'd0);
            nextCycle();
        end
        checkCycle("contStop1st", 1'b1, 1'b0, 1'b1, 2'd0);
        nextCycle();
        checkCycle("contStop2nd", 1'b1, 1'b0, 1'b1, 2'd0);
        bus.stop = 1'b1;
        nextCycle();
        bus.stop = 1'b0;
        checkCycle("stopDone", 1'b0, 1'b1, 1'b0, 2'd0);
        nextCycle();
        for (int k = 0; k < 6; k++) begin
            checkCycle("stopQuiet", 1'b0, 1'b0, 1'b0, 2'd0);
            nextCycle();
        end

        // Mid-slot mask change: slot 1 completes, scan moves to line 3.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0110);
        nextCycle();
        bus.start = 1'b0;
        expectPass("maskChange", 2, 2'd1, 2'd3, 2'd0, 2'd0, 0, 1, 4'b1000);

        // Clearing the current line mid-slot on the last slot ends the pass.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0010);
        nextCycle();
        bus.start = 1'b0;
        expectPass("maskClear", 1, 2'd1, 2'd0, 2'd0, 2'd0, 0, 2, 4'b0000);

        // Asynchronous reset while showing line 2.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0100);
        nextCycle();
        bus.start = 1'b0;
        nextCycle();
        checkCycle("preReset", 1'b1, 1'b0, 1'b1, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkCycle("asyncReset", 1'b0, 1'b0, 1'b0, 2'd0);
        #3;
        rst_n = 1'b1;
        nextCycle();
        for (int k = 0; k < 4; k++) begin
            checkCycle("idleAfterAsync", 1'b0, 1'b0, 1'b0, 2'd0);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1000);
        nextCycle();
        bus.start = 1'b0;
        expectPass("passAfterReset", 1, 2'd3, 2'd0, 2'd0, 2'd0, 0, -1, 4'b1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
